// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier scheduler.
// Holds the FSM state encoding and the requester-id width.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ID_W = 1;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add of A or S, then arithmetic shift right.
// Purely combinational; the caller owns the P register.
module booth_step #(
    parameter int W = 10
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] a,
    input  logic [W-1:0] s,
    output logic [W-1:0] p_next
);

    logic signed [W-1:0] sum;

    always_comb begin
        sum = p;
        case (p[1:0])
            2'b01:   sum = p + a;
            2'b10:   sum = p + s;
            default: sum = p;
        endcase
        p_next = sum >>> 1;
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Two-requester round-robin front end around a sequential radix-2 Booth multiplier.
// One operation in flight; the product is held in DONE until the consumer takes it.
module booth_mult_scheduler
    import booth_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [NUM_BITS-1:0]   req0_m,
    input  logic [NUM_BITS-1:0]   req0_r,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [NUM_BITS-1:0]   req1_m,
    input  logic [NUM_BITS-1:0]   req1_r,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [2*NUM_BITS-1:0] resp_p
);

    // P carries two guard bits so that -m stays representable for the most negative m
    localparam int PW = 2*NUM_BITS + 2;
    localparam int CW = $clog2(NUM_BITS + 1);

    state_t              state;
    logic                prio;
    logic [ID_W-1:0]     id;
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       a;
    logic [PW-1:0]       s;
    logic [PW-1:0]       p;
    logic [PW-1:0]       p_next;

    logic                gnt_any;
    logic                gnt_id;
    logic                hs;
    logic [NUM_BITS-1:0] sel_m;
    logic [NUM_BITS-1:0] sel_r;
    logic [NUM_BITS:0]   m_ext;
    logic [NUM_BITS:0]   m_neg;

    // Arbitration: a lone requester always wins; on contention the one not granted last wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = prio;
        if (state == IDLE && !rst) begin
            gnt_any = req0_valid | req1_valid;
            if (req0_valid && req1_valid)
                gnt_id = prio;
            else if (req1_valid)
                gnt_id = 1'b1;
            else
                gnt_id = 1'b0;
        end
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any &&  gnt_id;
    assign hs         = req0_ready | req1_ready;

    assign sel_m = gnt_id ? req1_m : req0_m;
    assign sel_r = gnt_id ? req1_r : req0_r;
    assign m_ext = {sel_m[NUM_BITS-1], sel_m};
    assign m_neg = -m_ext;

    booth_step #(
        .W (PW)
    ) u_step (
        .p      (p),
        .a      (a),
        .s      (s),
        .p_next (p_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            prio       <= 1'b0;
            id         <= '0;
            a          <= '0;
            s          <= '0;
            p          <= '0;
            resp_valid <= 1'b0;
            resp_p     <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        a     <= {m_ext, {(NUM_BITS+1){1'b0}}};
                        s     <= {m_neg, {(NUM_BITS+1){1'b0}}};
                        p     <= {{(NUM_BITS+1){1'b0}}, sel_r, 1'b0};
                        id    <= gnt_id;
                        prio  <= ~gnt_id;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Extra cycle after the last step registers the result, giving NUM_BITS+1 latency
                    if (cnt == CW'(NUM_BITS)) begin
                        resp_valid <= 1'b1;
                        resp_p     <= p[2*NUM_BITS:1];
                        resp_id    <= id;
                        state      <= DONE;
                    end else begin
                        p   <= p_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Self-checking bench: directed scenarios plus a shuffled sweep of every 4-bit operand pair.
// Expected products come from plain signed integer multiplication.
module tb_booth_mult_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_m, req0_r, req1_m, req1_r;
    logic         resp_valid, resp_ready;
    logic [0:0]   resp_id;
    logic [2*N-1:0] resp_p;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_mult_scheduler #(.NUM_BITS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_m     (req0_m),
        .req0_r     (req0_r),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_m     (req1_m),
        .req1_r     (req1_r),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p)
    );

    function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] r);
        int pm, pr;
        pm = $signed(m);
        pr = $signed(r);
        return 8'(pm * pr);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req0_m = 4'($urandom); req0_r = 4'($urandom);
        req1_m = 4'($urandom); req1_r = 4'($urandom);
    endtask

    task automatic run_op(input logic rid, input logic [3:0] m, input logic [3:0] r,
                          input int stall, input bit chk_lat);
        int n;
        logic [7:0] ep;
        ep = ref_prod(m, r);
        @(negedge clk);
        if (rid) begin req1_valid = 1'b1; req1_m = m; req1_r = r; end
        else     begin req0_valid = 1'b1; req0_m = m; req0_r = r; end
        resp_ready = (stall == 0);
        #1;
        n = 0;
        while (!(rid ? req1_ready : req0_ready) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        chk("grant", 32'(rid ? req1_ready : req0_ready), 32'(1));
        chk("ready_excl", 32'(req0_ready & req1_ready), 32'(0));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        scramble();
        n = 0;
        while (!resp_valid && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (chk_lat) chk("latency", 32'(n), 32'(N + 1));
        chk("product", 32'(resp_p), 32'(ep));
        chk("resp_id", 32'(resp_id), 32'(rid));
        if (stall > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk("stall_valid", 32'(resp_valid), 32'(1));
                chk("stall_p", 32'(resp_p), 32'(ep));
                chk("stall_id", 32'(resp_id), 32'(rid));
                chk("stall_ready", 32'({req0_ready, req1_ready}), 32'(0));
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            chk("release_valid", 32'(resp_valid), 32'(0));
            chk("release_idle", 32'(req0_ready | req1_ready), 32'(1));
            req0_valid = 1'b0; req1_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            chk("resp_drop", 32'(resp_valid), 32'(0));
        end
    endtask

    initial begin
        int n;
        logic g, exp_g, seen;
        logic [3:0] em, er;
        logic [7:0] order [256];
        logic [7:0] tmp;

        // Reset with both requesters already valid: readies must stay low
        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        scramble();
        #12;
        chk("rst_valid", 32'(resp_valid), 32'(0));
        chk("rst_p", 32'(resp_p), 32'(0));
        chk("rst_id", 32'(resp_id), 32'(0));
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Both valid continuously: grants alternate starting from requester 0
        exp_g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready | req1_ready) && n < 30) begin
                @(negedge clk); #1; n++;
            end
            g = req1_ready;
            chk("rr_grant", 32'(g), 32'(exp_g));
            chk("rr_excl", 32'(req0_ready & req1_ready), 32'(0));
            em = g ? req1_m : req0_m;
            er = g ? req1_r : req0_r;
            @(posedge clk); #1;
            scramble();
            n = 0;
            while (!resp_valid && n < 30) begin
                @(posedge clk); #1; n++;
            end
            chk("rr_id", 32'(resp_id), 32'(g));
            chk("rr_prod", 32'(resp_p), 32'(ref_prod(em, er)));
            exp_g = ~exp_g;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Directed products and latency
        run_op(1'b0, 4'd3, 4'hE, 0, 1'b1);
        run_op(1'b1, 4'h8, 4'h8, 0, 1'b1);
        run_op(1'b1, 4'h8, 4'h7, 0, 1'b1);

        // Consumer back-pressure for 10 cycles
        run_op(1'b0, 4'h5, 4'h6, 10, 1'b1);

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        req0_valid = 1'b1; req0_m = 4'h7; req0_r = 4'h7;
        #1;
        n = 0;
        while (!req0_ready && n < 30) begin
            @(negedge clk); #1; n++;
        end
        chk("abort_grant", 32'(req0_ready), 32'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1;
        #3;
        chk("abort_rst_valid", 32'(resp_valid), 32'(0));
        chk("abort_rst_ready", 32'(req0_ready), 32'(0));
        req0_valid = 1'b0;
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            seen = seen | resp_valid;
        end
        chk("abort_no_resp", 32'(seen), 32'(0));
        run_op(1'b1, 4'h5, 4'hD, 0, 1'b1);

        // Every operand pair, shuffled, on a random requester
        for (int i = 0; i < 256; i++) order[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j;
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            tmp = order[i];
            run_op(1'($urandom_range(1, 0)), tmp[7:4], tmp[3:0], 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
